// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcodes driven into the ALU, main-decoder ALU_OP
// values, R-type FUNCT codes, and the id_ex_stage buffer occupancy states.
package alu_pkg;

    // ALU opcodes as consumed by the ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-decoder ALU_OP field
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_SLT   = 2'b11
    } alu_op_e;

    // R-type FUNCT field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Occupancy of the two-entry elastic buffer (main register + skid)
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

endpackage

// File: rtl/alu_control.sv
// ALU control decode: maps main-decoder ALU_OP plus FUNCT to a 4-bit ALU
// opcode, flagging R-type function codes the ALU does not implement.
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       illegal
);

    // Opcode decode; unknown R-type FUNCT falls back to add and raises illegal
    always_comb begin
        op      = ALU_ADD;
        illegal = 1'b0;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_SLT: op = ALU_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: op = ALU_ADD;
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    FUNCT_NOR: op = ALU_NOR;
                    default: begin
                        op      = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                op      = ALU_ADD;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute boundary stage. Decodes the ALU opcode and selects operand B
// on the input side, then holds entries in a two-deep elastic buffer whose
// main register drives the ALU-facing outputs directly.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] RS_DATA,
    input  logic [DATA_W-1:0] RT_DATA,
    input  logic [15:0]       IMM,
    input  logic              ALU_SRC,
    input  logic [1:0]        ALU_OP,
    input  logic [5:0]        FUNCT,
    input  logic [ADDR_W-1:0] RD_ADDR,
    input  logic              REG_WRITE,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [3:0]        OP,
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic              WB_EN,
    output logic              ILLEGAL
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        op;
        logic [ADDR_W-1:0] wb_addr;
        logic              wb_en;
        logic              illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        a:       '0,
        b:       '0,
        op:      ALU_ADD,
        wb_addr: '0,
        wb_en:   1'b0,
        illegal: 1'b0
    };

    logic [3:0] dec_op;
    logic       dec_illegal;
    entry_t     new_entry;
    entry_t     main_q;
    entry_t     skid_q;
    buf_state_e state_q;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       in_fire;
    logic       out_fire;

    alu_control u_alu_control (
        .alu_op  (ALU_OP),
        .funct   (FUNCT),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    assign in_fire  = IN_VALID & in_ready_q;
    assign out_fire = out_valid_q & OUT_READY;

    // Assemble the incoming entry: sign-extended immediate or RT as operand B
    always_comb begin
        new_entry         = RESET_ENTRY;
        new_entry.a       = RS_DATA;
        new_entry.b       = ALU_SRC ? {{(DATA_W-16){IMM[15]}}, IMM} : RT_DATA;
        new_entry.op      = dec_op;
        new_entry.wb_addr = RD_ADDR;
        new_entry.wb_en   = REG_WRITE & ~dec_illegal;
        new_entry.illegal = dec_illegal;
    end

    // Buffer control: IN_READY is registered, so the skid absorbs the one
    // entry that can arrive while the main register is stalled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= RESET_ENTRY;
            skid_q      <= RESET_ENTRY;
        end else if (FLUSH) begin
            state_q     <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        main_q      <= new_entry;
                        state_q     <= BUF_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: main_q <= new_entry;
                        2'b01: begin
                            state_q     <= BUF_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                        2'b10: begin
                            skid_q     <= new_entry;
                            state_q    <= BUF_TWO;
                            in_ready_q <= 1'b0;
                        end
                        default: state_q <= BUF_ONE;
                    endcase
                end
                BUF_TWO: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state_q    <= BUF_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= BUF_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign A         = main_q.a;
    assign B         = main_q.b;
    assign OP        = main_q.op;
    assign WB_ADDR   = main_q.wb_addr;
    assign WB_EN     = main_q.wb_en;
    assign ILLEGAL   = main_q.illegal;

endmodule
